ring_token_arbiter: RTL and testbench

- Round-robin arbiter that shares one resource among N requesters.
- A one-hot token ring, a rotating pointer equivalent to the team's ring counter, sets search priority.
- The block grants exactly one requester at a time, holds the grant until release or timeout, then advances the token past the served requester.
- It sits between the requester blocks and the shared datapath. It drives the datapath select through gnt_id.

---
 rtl/ring_token_arbiter.sv | 106 ++++++++++
 tb/tb_ring_token_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ring_token_arbiter.sv
// Round-robin arbiter: a one-hot token sets the search start, one grant is held
// until release or MAX_HOLD, and a one-cycle gap follows every grant.
`timescale 1ns/1ps

module ring_token_arbiter #(
    parameter int N        = 8,
    parameter int IDW      = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic           timeout,
    output logic [N-1:0]   token
);

    localparam int HW = $clog2(MAX_HOLD + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [1:0]     state;
    logic [HW-1:0]  hold;
    int             tok_idx;
    int             idx;
    logic           found;
    logic [IDW-1:0] sel;
    logic [N-1:0]   sel_onehot;
    logic [N-1:0]   next_token;
    logic           owner_req;

    // Scan starts at the token bit and wraps, so the token holder has top priority.
    always_comb begin
        tok_idx = 0;
        for (int i = 0; i < N; i++) begin
            if (token[i]) tok_idx = i;
        end
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (tok_idx + k) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = IDW'(idx);
            end
        end
    end

    assign sel_onehot = {{(N-1){1'b0}}, 1'b1} << sel;
    assign next_token = {{(N-1){1'b0}}, 1'b1} << ((int'(gnt_id) + 1) % N);
    assign owner_req  = req[gnt_id];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            token   <= {{(N-1){1'b0}}, 1'b1};
            gnt     <= '0;
            gnt_id  <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
            hold    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    timeout <= 1'b0;
                    if (en && found) begin
                        gnt    <= sel_onehot;
                        gnt_id <= sel;
                        busy   <= 1'b1;
                        hold   <= HW'(1);
                        state  <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!owner_req || hold == HW'(MAX_HOLD)) begin
                        gnt     <= '0;
                        busy    <= 1'b0;
                        token   <= next_token;
                        hold    <= '0;
                        timeout <= owner_req;
                        state   <= ST_GAP;
                    end else begin
                        hold <= hold + HW'(1);
                    end
                end
                ST_GAP: begin
                    timeout <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    gnt     <= '0;
                    busy    <= 1'b0;
                    timeout <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ring_token_arbiter.sv
// Directed bench for ring_token_arbiter: reset, round-robin order, token priority,
// timeout, enable gating and asynchronous reset during a grant.
`timescale 1ns/1ps

module tb_ring_token_arbiter;

    localparam int N        = 8;
    localparam int IDW      = 3;
    localparam int MAX_HOLD = 16;

    logic           clk;
    logic           reset;
    logic           en;
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           busy;
    logic           timeout;
    logic [N-1:0]   token;

    int total;
    int bad;
    logic prev_timeout;

    ring_token_arbiter #(.N(N), .IDW(IDW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout),
        .token   (token)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] r, input logic e);
        req = r;
        en  = e;
    endtask

    task automatic check_invariants();
        checkOutput("inv_gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        checkOutput("inv_token_onehot", 32'($onehot(token)), 32'd1);
        checkOutput("inv_busy", 32'(busy), 32'(gnt != '0));
        if (gnt != '0) checkOutput("inv_gnt_id", 32'(gnt[gnt_id]), 32'd1);
        checkOutput("inv_timeout_pulse", 32'(timeout && prev_timeout), 32'd0);
        prev_timeout = timeout;
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        check_invariants();
    endtask

    initial begin
        total = 0;
        bad = 0;
        prev_timeout = 1'b0;
        reset = 1'b0;
        applyStimulus(8'hFF, 1'b1);

        for (int c = 0; c < 10; c++) begin
            tick();
            checkOutput("rst_gnt", 32'(gnt), 32'h00);
            checkOutput("rst_token", 32'(token), 32'h01);
            checkOutput("rst_busy", 32'(busy), 32'd0);
            checkOutput("rst_timeout", 32'(timeout), 32'd0);
        end

        reset = 1'b1;
        tick();
        checkOutput("first_gnt", 32'(gnt), 32'h01);
        checkOutput("first_gnt_id", 32'(gnt_id), 32'd0);
        checkOutput("first_busy", 32'(busy), 32'd1);

        // Round robin: each owner holds 2 cycles, drops req, then re-raises it.
        for (int i = 0; i < N; i++) begin
            checkOutput("rr_gnt", 32'(gnt), 32'(1) << i);
            checkOutput("rr_gnt_id", 32'(gnt_id), 32'(i));
            tick();
            checkOutput("rr_hold", 32'(gnt), 32'(1) << i);
            applyStimulus(8'hFF & ~(8'h01 << i), 1'b1);
            tick();
            checkOutput("rr_gap_gnt", 32'(gnt), 32'h00);
            checkOutput("rr_gap_token", 32'(token), 32'(1) << ((i + 1) % N));
            checkOutput("rr_gap_id_held", 32'(gnt_id), 32'(i));
            applyStimulus(8'hFF, 1'b1);
            tick();
            checkOutput("rr_idle_gnt", 32'(gnt), 32'h00);
            tick();
        end
        checkOutput("rr_wrap_gnt", 32'(gnt), 32'h01);

        // Token priority: move token to bit 5, then req=0x09 must pick requester 0.
        applyStimulus(8'h00, 1'b1);
        tick();
        checkOutput("tp_token_a", 32'(token), 32'h02);
        tick();
        applyStimulus(8'h10, 1'b1);
        tick();
        checkOutput("tp_gnt4", 32'(gnt), 32'h10);
        applyStimulus(8'h00, 1'b1);
        tick();
        checkOutput("tp_token_20", 32'(token), 32'h20);
        applyStimulus(8'h09, 1'b1);
        tick();
        tick();
        checkOutput("tp_gnt0", 32'(gnt), 32'h01);
        checkOutput("tp_gnt_id0", 32'(gnt_id), 32'd0);
        applyStimulus(8'h00, 1'b1);
        tick();
        checkOutput("tp_next_token", 32'(token), 32'h02);
        tick();

        // Timeout with requester 2 holding req constantly.
        applyStimulus(8'h04, 1'b1);
        tick();
        for (int k = 0; k < MAX_HOLD; k++) begin
            checkOutput("to_hold_gnt", 32'(gnt), 32'h04);
            checkOutput("to_hold_timeout", 32'(timeout), 32'd0);
            if (k < MAX_HOLD - 1) tick();
        end
        tick();
        checkOutput("to_gnt", 32'(gnt), 32'h00);
        checkOutput("to_pulse", 32'(timeout), 32'd1);
        checkOutput("to_token", 32'(token), 32'h08);
        tick();
        checkOutput("to_pulse_end", 32'(timeout), 32'd0);
        checkOutput("to_idle_gnt", 32'(gnt), 32'h00);
        tick();
        checkOutput("to_regrant", 32'(gnt), 32'h04);
        applyStimulus(8'h00, 1'b1);
        tick();
        tick();

        // Enable gating blocks new grants only.
        applyStimulus(8'h10, 1'b0);
        for (int c = 0; c < 20; c++) begin
            tick();
            checkOutput("en_off_gnt", 32'(gnt), 32'h00);
        end
        applyStimulus(8'h10, 1'b1);
        tick();
        checkOutput("en_on_gnt", 32'(gnt), 32'h10);
        applyStimulus(8'h10, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput("en_drop_hold", 32'(gnt), 32'h10);
        end
        applyStimulus(8'h00, 1'b0);
        tick();
        checkOutput("en_release", 32'(gnt), 32'h00);
        checkOutput("en_token", 32'(token), 32'h20);
        tick();

        // Asynchronous reset while requester 6 holds the grant.
        applyStimulus(8'h40, 1'b1);
        tick();
        checkOutput("ar_gnt", 32'(gnt), 32'h40);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("ar_gnt_clr", 32'(gnt), 32'h00);
        checkOutput("ar_busy", 32'(busy), 32'd0);
        checkOutput("ar_token", 32'(token), 32'h01);
        checkOutput("ar_timeout", 32'(timeout), 32'd0);
        tick();
        reset = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
